serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial add/subtract unit for the ULA.
- Reuses one 1-bit full-adder slice iterated LSB-first over WIDTH clocks, instead of a WIDTH-wide ripple chain.
- Provides the addition direction alongside subtraction; subtraction is performed as A + ~B + 1.
- Sits beside the combinational ULA as an area-minimal arithmetic path with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  1  0 = add (A+B), 1 = subtract (A-B).
- a  input  WIDTH  operand A, latched when start is accepted.
- b  input  WIDTH  operand B, latched when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle on.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry out. In sub mode, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0, zero=0; bit counter=0; internal shift registers=0.
- Reset mid-operation: the operation is abandoned, all of the above apply on the same edge, and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge: latch a and op; latch b, inverted when op=1; carry register = op; counter=0; go to RUN.
- RUN:
  - busy=1.
  - Each edge: bit0 of the A and B shift registers plus the carry register pass through the 1-bit full-adder slice.
  - The sum bit shifts into the MSB of the result shift register; the carry register takes the slice carry-out; operand registers shift right by 1; counter increments.
  - On the edge where counter == WIDTH-1 (the last bit):
    - record carry-into-MSB as the carry register value before that edge;
    - go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - On entry: result = assembled shift register; cout = final carry; overflow = carry-into-MSB XOR final carry; zero = (result == 0).
  - Next edge returns to IDLE.
  - start in DONE is ignored.
- Latency: start sampled at edge k gives busy=1 for cycles k..k+WIDTH-1 and done=1 during cycle k+WIDTH. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Outputs hold:
  - result/cout/overflow/zero change only on DONE entry or on reset;
  - they hold their previous values while busy and in IDLE.
- start while busy=1: ignored. Operands are not re-latched and timing is unaffected.
- a, b and op may change freely after acceptance with no effect on the operation in progress.
- Arithmetic:
  - modulo 2^WIDTH, no saturation;
  - cout is a pure unsigned carry, not an inverted borrow.

Test Plan:
- WIDTH=8, add 0x3A+0x25 -> done exactly 8 cycles after the start-sampled cycle, result=0x5F, cout=0, overflow=0, zero=0.
- Add 0xFF+0x01 -> result=0x00, cout=1, overflow=0, zero=1.
- Sub 0x05-0x07 -> result=0xFE, cout=0 (borrow), overflow=0, zero=0.
- Sub 0x80-0x01 -> result=0x7F, cout=1, overflow=1; then add 0x7F+0x01 -> result=0x80, overflow=1, cout=0.
- Start 0x10+0x10, pulse start again with a=0xFF at cycle 3 -> second start ignored, result=0x20. A start in the DONE cycle is also ignored; the next accepted start is in IDLE.
- Assert rst at cycle 4 of an operation -> same edge busy=0 and all outputs 0, no done pulse; a new start afterwards completes normally with correct values.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for the bit-serial add/subtract unit.
// The master issues requests; the slave (the unit) returns the result and flags.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder slice iterated LSB-first over WIDTH clocks.
// Subtraction is A + ~B + 1, so the carry register is seeded with op.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_addsub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  logic sum_bit;
  logic slice_cout;

  assign sum_bit    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign slice_cout = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.op ? ~bus.b : bus.b;
          carry_d = bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sr_d = {sum_bit, res_sr_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB slice
          result_d = res_sr_d;
          cout_d   = slice_cout;
          ovf_d    = carry_q ^ slice_cout;
          zero_d   = (res_sr_d == '0);
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: the driver queues expected results, the monitor checks each done pulse.
module tb_serial_addsub;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             o;
    logic             z;
    longint           dpos;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint pos_cnt = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", pos_cnt, e.dpos);
        check("result",     bus.result, e.res);
        check("cout",       bus.cout, e.c);
        check("overflow",   bus.overflow, e.o);
        check("zero",       bus.zero, e.z);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
  endtask

  // Issue one operation from IDLE and queue its expected outcome.
  task automatic issue(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] er, input logic ec, input logic eo, input logic ez);
    exp_t e;
    wait_idle();
    e.res = er; e.c = ec; e.o = eo; e.z = ez;
    e.dpos = pos_cnt + 1 + WIDTH;
    sb.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op = ~op; bus.a = ~a; bus.b = ~b;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},   bus.busy, 0);
    check({name, "_done"},   bus.done, 0);
    check({name, "_result"}, bus.result, 0);
    check({name, "_flags"},  {bus.cout, bus.overflow, bus.zero}, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 1, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    issue(1'b0, 8'h3A, 8'h25, 8'h5F, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);

    // Restart while busy and start during DONE must both be ignored.
    issue(1'b0, 8'h10, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("hold_result_busy", bus.result, 8'h80);
    bus.start = 1'b1; bus.a = 8'hFF; bus.op = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int n = 0;
      while (bus.done !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("done_timeout", 1, 0);
    end
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'h01; bus.b = 8'h01;
    @(negedge clk);
    check("start_in_done_ignored", bus.busy, 0);
    check("hold_result_idle", bus.result, 8'h20);
    bus.start = 1'b0;

    // Reset in the middle of an operation abandons it.
    issue(1'b0, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    check("no_done_after_reset", bus.result, 0);

    issue(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
